// File: rtl/result_demux8_if.sv
// Result-bus handshake bundle between the ALU result producer and result_demux8.
// The master drives words in and takes lanes out; the slave is the demux itself.
interface result_demux8_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned COUNT_W = 16
);
    localparam int unsigned LANES = 8;

    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_ctl;
    logic [WIDTH-1:0]         in_data;
    logic [LANES-1:0]         out_valid;
    logic [LANES-1:0]         out_ready;
    logic [LANES*WIDTH-1:0]   out_data;
    logic [COUNT_W-1:0]       accept_count;

    modport master (
        output in_valid, in_ctl, in_data, out_ready,
        input  in_ready, out_valid, out_data, accept_count
    );

    modport slave (
        input  in_valid, in_ctl, in_data, out_ready,
        output in_ready, out_valid, out_data, accept_count
    );
endinterface

// File: rtl/result_demux8.sv
// 1:8 result demultiplexer: each lane has a one-entry holding register with its
// own valid/ready handshake, so a stalled consumer only blocks its own lane.
module result_demux8 #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned COUNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    result_demux8_if.slave    bus
);
    localparam int unsigned LANES = 8;

    logic [LANES-1:0]   valid_q, valid_d;
    logic [WIDTH-1:0]   data_q [LANES];
    logic [WIDTH-1:0]   data_d [LANES];
    logic [COUNT_W-1:0] count_q, count_d;

    logic               in_ready_c;
    logic               accept_c;
    logic [LANES-1:0]   load_oh_c;
    logic [LANES-1:0]   drain_c;

    // A lane can take a word if empty or if its current word leaves this cycle.
    always_comb begin
        in_ready_c = ~valid_q[bus.in_ctl] | bus.out_ready[bus.in_ctl];
        accept_c   = bus.in_valid & in_ready_c;
        load_oh_c  = accept_c ? (LANES'(1) << bus.in_ctl) : '0;
        drain_c    = valid_q & bus.out_ready;
    end

    // Next state: refill wins over drain on the same lane; data is kept on drain.
    always_comb begin
        valid_d = (valid_q & ~drain_c) | load_oh_c;
        count_d = accept_c ? count_q + COUNT_W'(1) : count_q;
        for (int k = 0; k < LANES; k++) begin
            data_d[k] = load_oh_c[k] ? bus.in_data : data_q[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int k = 0; k < LANES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = valid_q;
    assign bus.accept_count = count_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign bus.out_data[g*WIDTH +: WIDTH] = data_q[g];
    end
endmodule

// File: tb/tb_result_demux8.sv
// Directed + randomized bench for result_demux8 against a lane-table reference model.
module tb_result_demux8;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    logic clk;
    logic reset;

    result_demux8_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

    result_demux8 #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which lanes hold a word, what they hold, words accepted.
    logic [7:0]  mv;
    logic [31:0] md [8];
    int          mcnt;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv   = '0;
        mcnt = 0;
        for (int k = 0; k < 8; k++) md[k] = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, " out_valid"}, 256'(bus.out_valid), 256'(mv));
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s lane%0d", tag, k), 256'(bus.out_data[k*W +: W]), 256'(md[k]));
        chk({tag, " count"}, 256'(bus.accept_count), 256'(mcnt % (1 << CW)));
    endtask

    // One clock: drive at negedge, check in_ready, step model, check registered state.
    task automatic cycle(input string tag, input logic iv, input logic [2:0] c,
                         input logic [31:0] d, input logic [7:0] ordy, output logic acc);
        logic exp_rdy;
        bus.in_valid  = iv;
        bus.in_ctl    = c;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !mv[c] || ordy[c];
        chk({tag, " in_ready"}, 256'(bus.in_ready), 256'(exp_rdy));
        acc = iv && exp_rdy;
        for (int k = 0; k < 8; k++)
            if (mv[k] && ordy[k]) mv[k] = 1'b0;
        if (acc) begin
            mv[c] = 1'b1;
            md[c] = d;
            mcnt  = mcnt + 1;
        end
        @(posedge clk);
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic        iv;
        logic [2:0]  c;
        logic [31:0] d;
        logic [7:0]  ordy;

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_ctl = '0; bus.in_data = '0; bus.out_ready = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset then idle: every destination is ready.
        check_state("reset");
        for (int i = 0; i < 8; i++) begin
            bus.in_ctl = 3'(i);
            #1;
            chk($sformatf("idle_ready ctl%0d", i), 256'(bus.in_ready), 256'(1));
        end
        @(negedge clk);

        // Single delivery to lane 5, then hold for 10 cycles.
        cycle("single", 1'b1, 3'd5, 32'hDEADBEEF, 8'h00, acc);
        chk("single_valid", 256'(bus.out_valid), 256'(8'h20));
        chk("single_lane5", 256'(bus.out_data[5*W +: W]), 256'(32'hDEADBEEF));
        for (int i = 0; i < 10; i++) cycle("hold", 1'b0, 3'd5, 32'h0, 8'h00, acc);
        chk("single_count", 256'(bus.accept_count), 256'(1));

        // Stall on lane 5, serve lane 2 meanwhile, then release lane 5.
        cycle("stall", 1'b1, 3'd5, 32'hCAFEF00D, 8'h00, acc);
        chk("stall_noacc", 256'(acc), 256'(0));
        cycle("other", 1'b1, 3'd2, 32'h1234, 8'h00, acc);
        cycle("stall2", 1'b1, 3'd5, 32'hCAFEF00D, 8'h00, acc);
        cycle("release", 1'b1, 3'd5, 32'hCAFEF00D, 8'h20, acc);
        chk("release_lane5", 256'(bus.out_data[5*W +: W]), 256'(32'hCAFEF00D));

        // Back-to-back into lane 3 with its consumer always ready.
        for (int i = 1; i <= 8; i++) begin
            cycle("b2b", 1'b1, 3'd3, 32'(i), 8'h08, acc);
            chk("b2b_valid3", 256'(bus.out_valid[3]), 256'(1));
        end
        cycle("b2b_end", 1'b0, 3'd3, 32'h0, 8'h08, acc);

        // Fan-out to all lanes, then drain everything at once.
        do_reset();
        for (int k = 0; k < 8; k++) cycle("fan", 1'b1, 3'(k), 32'(16 * k + k), 8'h00, acc);
        chk("fan_full", 256'(bus.out_valid), 256'(8'hFF));
        cycle("drain", 1'b0, 3'd0, 32'h0, 8'hFF, acc);
        chk("drain_empty", 256'(bus.out_valid), 256'(8'h00));
        chk("drain_keep7", 256'(bus.out_data[7*W +: W]), 256'(32'h77));

        // Asynchronous reset mid-stream with lanes full.
        for (int k = 0; k < 8; k++) cycle("refill", 1'b1, 3'(k), $urandom, 8'h00, acc);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_state("async_rst");
        chk("async_rst_ready", 256'(bus.in_ready), 256'(1));
        @(negedge clk);
        reset = 1'b0;

        // Counter wrap: 17 accepts on a 4-bit counter.
        for (int i = 0; i < 17; i++) cycle("wrap", 1'b1, 3'(i), 32'(i), 8'hFF, acc);
        chk("wrap_count", 256'(bus.accept_count), 256'(1));

        // Randomized traffic; a refused word is held stable until taken.
        iv = 1'b0; c = '0; d = '0; acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!iv || acc) begin
                iv = ($urandom_range(0, 3) != 0);
                c  = 3'($urandom_range(0, 7));
                d  = $urandom;
            end
            ordy = 8'($urandom) & 8'($urandom);
            cycle("rand", iv, c, d, ordy, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
